// File: rtl/f2_img_sequencer.sv
// Image/rotation/inversion sequencer for the frame-buffer display path.
// Button events stage into pending registers; outputs update only at frame boundaries.
module f2_img_sequencer #(
    parameter int AUTO_FRAMES = 120,
    parameter int NUM_IMAGES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       forwards,
    input  logic       backwards,
    input  logic       rotate,
    input  logic       inverse,
    input  logic       auto_mode,
    input  logic       vsync,
    output logic [1:0] current_img,
    output logic [1:0] rotation,
    output logic       invert,
    output logic       frame_tick
);

    typedef enum logic {MANUAL, AUTO} state_t;

    localparam logic [1:0] LAST_IMG = 2'(NUM_IMAGES - 1);
    localparam logic [9:0] CNT_LAST = 10'(AUTO_FRAMES - 1);

    state_t     state, state_d;
    logic [9:0] cnt, cnt_d;
    logic [1:0] pend_img, pend_img_d;
    logic [1:0] pend_rot;
    logic       pend_inv;
    logic       fwd_q, bwd_q, rot_q, inv_q, vs_q;
    logic       armed;
    logic       fwd_ev, bwd_ev, rot_ev, inv_ev;
    logic       step_fwd, step_bwd, adv;

    // armed blocks events on the first cycle after reset release,
    // so a button held through reset is absorbed as the old level
    assign fwd_ev   = armed & forwards  & ~fwd_q;
    assign bwd_ev   = armed & backwards & ~bwd_q;
    assign rot_ev   = armed & rotate    & ~rot_q;
    assign inv_ev   = armed & inverse   & ~inv_q;
    assign step_fwd = fwd_ev & ~bwd_ev;
    assign step_bwd = bwd_ev & ~fwd_ev;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        adv        = 1'b0;
        pend_img_d = pend_img;
        unique case (state)
            MANUAL: if (auto_mode)  state_d = AUTO;
            AUTO:   if (!auto_mode) state_d = MANUAL;
            default: state_d = MANUAL;
        endcase
        if (state_d != state) begin
            cnt_d = '0;
        end else if (state == AUTO) begin
            if (step_fwd || step_bwd) begin
                cnt_d = '0;
            end else if (frame_tick) begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    adv   = 1'b1;
                end else begin
                    cnt_d = cnt + 10'd1;
                end
            end
        end
        if (step_fwd || adv)
            pend_img_d = (pend_img == LAST_IMG) ? 2'd0 : pend_img + 2'd1;
        else if (step_bwd)
            pend_img_d = (pend_img == 2'd0) ? LAST_IMG : pend_img - 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= MANUAL;
            cnt         <= '0;
            pend_img    <= '0;
            pend_rot    <= '0;
            pend_inv    <= 1'b0;
            fwd_q       <= 1'b0;
            bwd_q       <= 1'b0;
            rot_q       <= 1'b0;
            inv_q       <= 1'b0;
            vs_q        <= 1'b1;
            armed       <= 1'b0;
            frame_tick  <= 1'b0;
            current_img <= '0;
            rotation    <= '0;
            invert      <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pend_img   <= pend_img_d;
            pend_rot   <= pend_rot + {1'b0, rot_ev};
            pend_inv   <= pend_inv ^ inv_ev;
            fwd_q      <= forwards;
            bwd_q      <= backwards;
            rot_q      <= rotate;
            inv_q      <= inverse;
            vs_q       <= vsync;
            armed      <= 1'b1;
            frame_tick <= vs_q & ~vsync;
            // outputs take the pre-edge pending values: tear-free update
            if (frame_tick) begin
                current_img <= pend_img;
                rotation    <= pend_rot;
                invert      <= pend_inv;
            end
        end
    end

endmodule

// File: tb/tb_f2_img_sequencer.sv
// Directed bench for f2_img_sequencer with AUTO_FRAMES=3, NUM_IMAGES=4.
module tb_f2_img_sequencer;

    logic       clk = 1'b0;
    logic       reset, forwards, backwards, rotate, inverse;
    logic       auto_mode, vsync;
    logic [1:0] current_img, rotation;
    logic       invert, frame_tick;

    int vectors = 0;
    int errs    = 0;

    f2_img_sequencer #(.AUTO_FRAMES(3), .NUM_IMAGES(4)) dut (
        .clk(clk), .reset(reset), .forwards(forwards),
        .backwards(backwards), .rotate(rotate), .inverse(inverse),
        .auto_mode(auto_mode), .vsync(vsync),
        .current_img(current_img), .rotation(rotation),
        .invert(invert), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // one vsync falling edge; outputs are settled when this returns
    task automatic frame();
        vsync = 1'b0;
        step(2);
        vsync = 1'b1;
        step(3);
    endtask

    task automatic press_fwd();
        forwards = 1'b1; step(1); forwards = 1'b0; step(1);
    endtask

    task automatic press_bwd();
        backwards = 1'b1; step(1); backwards = 1'b0; step(1);
    endtask

    task automatic press_rot();
        rotate = 1'b1; step(1); rotate = 1'b0; step(1);
    endtask

    initial begin
        reset = 1'b0; forwards = 1'b0; backwards = 1'b0;
        rotate = 1'b0; inverse = 1'b0; auto_mode = 1'b0; vsync = 1'b1;
        step(3);
        check("rst_img", current_img, 0);
        check("rst_rot", rotation, 0);
        check("rst_inv", invert, 0);
        check("rst_tick", frame_tick, 0);
        reset = 1'b1;
        step(3);

        // forwards press mid-frame, held back until frame_tick
        press_fwd();
        step(4);
        check("fwd_hold", current_img, 0);
        vsync = 1'b0;
        step(1);
        check("tick_hi", frame_tick, 1);
        check("fwd_in_tick", current_img, 0);
        step(1);
        check("tick_lo", frame_tick, 0);
        check("fwd_out", current_img, 1);
        vsync = 1'b1;
        step(3);
        check("no_tick_vs_hi", frame_tick, 0);

        // asynchronous reset takes effect immediately
        reset = 1'b0;
        #1;
        check("async_rst", current_img, 0);
        step(2);
        reset = 1'b1;
        step(3);

        // five backwards presses in one frame: 0 -> 3
        repeat (5) press_bwd();
        check("bwd_hold", current_img, 0);
        frame();
        check("bwd5", current_img, 3);

        // simultaneous forwards/backwards cancel
        forwards = 1'b1; backwards = 1'b1; step(1);
        forwards = 1'b0; backwards = 1'b0; step(1);
        frame();
        frame();
        check("cancel", current_img, 3);

        // five rotates plus one inverse
        repeat (5) press_rot();
        inverse = 1'b1; step(1); inverse = 1'b0; step(1);
        check("rot_hold", rotation, 0);
        frame();
        check("rot5", rotation, 1);
        check("inv1", invert, 1);

        // press during the frame_tick cycle lands one frame later
        vsync = 1'b0;
        step(1);
        rotate = 1'b1;
        step(1);
        rotate = 1'b0; vsync = 1'b1;
        step(3);
        check("tick_press_a", rotation, 1);
        frame();
        check("tick_press_b", rotation, 2);

        // button held through reset release: no event
        reset = 1'b0; forwards = 1'b1;
        step(2);
        check("rst2_rot", rotation, 0);
        reset = 1'b1;
        step(3);
        forwards = 1'b0;
        step(2);
        frame();
        check("held_rst", current_img, 0);

        // slideshow with AUTO_FRAMES=3
        auto_mode = 1'b1;
        step(2);
        frame(); frame(); frame();
        check("auto_t3", current_img, 0);
        frame();
        check("auto_t4", current_img, 1);
        frame(); frame();
        check("auto_t6", current_img, 1);
        frame();
        check("auto_t7", current_img, 2);

        // forwards restarts the frame count
        press_fwd();
        frame();
        check("auto_fwd", current_img, 3);
        frame(); frame();
        check("auto_t10", current_img, 3);
        frame();
        check("auto_t11", current_img, 0);

        // forwards coinciding with expiry: single advance only
        frame();
        vsync = 1'b0;
        step(1);
        forwards = 1'b1;
        step(1);
        forwards = 1'b0; vsync = 1'b1;
        step(3);
        frame();
        check("no_double", current_img, 1);

        // back to manual: image holds
        auto_mode = 1'b0;
        step(2);
        repeat (4) frame();
        check("manual_hold", current_img, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
